// File: rtl/practice_pkg.sv
// practice_pkg: shared types, ASCII constants and key helpers for the
// letter-practice round sequencer.
package practice_pkg;

  typedef enum logic [2:0] {
    IDLE,
    PICK,
    WAIT,
    FEEDBACK,
    DONE
  } state_t;

  localparam logic [7:0] ASCII_A  = 8'h41;
  localparam logic [7:0] ASCII_Z  = 8'h5A;
  localparam logic [7:0] ASCII_LA = 8'h61;
  localparam logic [7:0] ASCII_LZ = 8'h7A;
  localparam logic [7:0] CASE_OFS = 8'h20;
  localparam logic [7:0] BLANK    = 8'h00;

  // Fold lowercase a-z onto uppercase; every other code passes through.
  function automatic logic [7:0] normalise_key(input logic [7:0] code);
    if (code >= ASCII_LA && code <= ASCII_LZ) begin
      return code - CASE_OFS;
    end
    return code;
  endfunction

  function automatic logic is_upper_letter(input logic [7:0] code);
    return (code >= ASCII_A) && (code <= ASCII_Z);
  endfunction

endpackage

// File: rtl/letter_lfsr.sv
// letter_lfsr: free-running 5-bit Fibonacci LFSR (x^5 + x^3 + 1) used as
// the target-letter source. Maximal length, so it never reaches zero.
// Ports:
//   clk    in   system clock
//   reset  in   asynchronous active-high reset, loads 5'b00001
//   value  out  current LFSR state
module letter_lfsr (
  input  logic       clk,
  input  logic       reset,
  output logic [4:0] value
);

  logic [4:0] value_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      value_q <= 5'b00001;
    end else begin
      value_q <= {value_q[3:0], value_q[4] ^ value_q[2]};
    end
  end

  assign value = value_q;

endmodule

// File: rtl/practice_controller.sv
// practice_controller: round sequencer for the letter-practice screen.
// Picks a pseudo-random letter A-Z, waits for a keystroke or timeout,
// scores it, holds hit/miss feedback, and repeats for NUM_ROUNDS rounds.
// Ports:
//   clk        in   system clock (rising edge)
//   reset      in   asynchronous active-high reset
//   start      in   one-cycle pulse, begins a game from IDLE or DONE
//   key_valid  in   one-cycle strobe qualifying key_code
//   key_code   in   ASCII code of pressed key
//   letter     out  target ASCII letter, 0x00 when no round is active
//   hit        out  high during feedback after a correct key
//   miss       out  high during feedback after a wrong key or timeout
//   score      out  correct rounds in the current game
//   round      out  completed rounds in the current game
//   busy       out  high outside IDLE and DONE
//   done       out  high in DONE
module practice_controller
  import practice_pkg::*;
#(
  parameter int unsigned TIMEOUT_TICKS  = 100_000_000,
  parameter int unsigned FEEDBACK_TICKS = 25_000_000,
  parameter int unsigned NUM_ROUNDS     = 10
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic       key_valid,
  input  logic [7:0] key_code,
  output logic [7:0] letter,
  output logic       hit,
  output logic       miss,
  output logic [7:0] score,
  output logic [7:0] round,
  output logic       busy,
  output logic       done
);

  localparam int unsigned CW = 27;
  localparam logic [CW-1:0] TO_LAST = CW'(TIMEOUT_TICKS - 1);
  localparam logic [CW-1:0] FB_LAST = CW'(FEEDBACK_TICKS - 1);
  localparam logic [7:0]    ROUNDS  = 8'(NUM_ROUNDS);

  state_t        state_q;
  logic [7:0]    letter_q;
  logic          hit_q;
  logic          miss_q;
  logic [7:0]    score_q;
  logic [7:0]    round_q;
  logic          busy_q;
  logic          done_q;
  logic [CW-1:0] to_cnt_q;
  logic [CW-1:0] fb_cnt_q;

  logic [4:0]    lfsr_value;
  logic [7:0]    key_norm;
  logic          key_accept;
  logic          lfsr_ok;
  logic [7:0]    score_d;
  logic [7:0]    round_d;

  letter_lfsr u_lfsr (
    .clk   (clk),
    .reset (reset),
    .value (lfsr_value)
  );

  always_comb begin
    key_norm   = normalise_key(key_code);
    key_accept = key_valid && is_upper_letter(key_norm);
    lfsr_ok    = (lfsr_value != 5'd0) && (lfsr_value <= 5'd26);
    score_d    = score_q + 8'd1;
    round_d    = round_q + 8'd1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      letter_q <= BLANK;
      hit_q    <= 1'b0;
      miss_q   <= 1'b0;
      score_q  <= '0;
      round_q  <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      to_cnt_q <= '0;
      fb_cnt_q <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          letter_q <= BLANK;
          if (start) begin
            score_q <= '0;
            round_q <= '0;
            busy_q  <= 1'b1;
            state_q <= PICK;
          end
        end

        // Values 27..31 have no letter; retry on the next LFSR step.
        PICK: begin
          if (lfsr_ok) begin
            letter_q <= ASCII_A - 8'd1 + {3'b000, lfsr_value};
            to_cnt_q <= '0;
            state_q  <= WAIT;
          end
        end

        // An accepted key takes priority over a timeout in the same cycle.
        WAIT: begin
          if (key_accept) begin
            if (key_norm == letter_q) begin
              hit_q   <= 1'b1;
              score_q <= score_d;
            end else begin
              miss_q <= 1'b1;
            end
            fb_cnt_q <= '0;
            state_q  <= FEEDBACK;
          end else if (to_cnt_q == TO_LAST) begin
            miss_q   <= 1'b1;
            fb_cnt_q <= '0;
            state_q  <= FEEDBACK;
          end else begin
            to_cnt_q <= to_cnt_q + 1'b1;
          end
        end

        FEEDBACK: begin
          if (fb_cnt_q == FB_LAST) begin
            hit_q   <= 1'b0;
            miss_q  <= 1'b0;
            round_q <= round_d;
            if (round_d == ROUNDS) begin
              letter_q <= BLANK;
              busy_q   <= 1'b0;
              done_q   <= 1'b1;
              state_q  <= DONE;
            end else begin
              state_q <= PICK;
            end
          end else begin
            fb_cnt_q <= fb_cnt_q + 1'b1;
          end
        end

        DONE: begin
          if (start) begin
            done_q  <= 1'b0;
            score_q <= '0;
            round_q <= '0;
            busy_q  <= 1'b1;
            state_q <= PICK;
          end
        end

        default: state_q <= IDLE;
      endcase
    end
  end

  assign letter = letter_q;
  assign hit    = hit_q;
  assign miss   = miss_q;
  assign score  = score_q;
  assign round  = round_q;
  assign busy   = busy_q;
  assign done   = done_q;

endmodule

// File: tb/tb_practice_controller.sv
// tb_practice_controller: directed self-checking bench for
// practice_controller with TIMEOUT_TICKS=16, FEEDBACK_TICKS=4, NUM_ROUNDS=3.
module tb_practice_controller;

  logic       clk = 1'b0;
  logic       reset;
  logic       start;
  logic       key_valid;
  logic [7:0] key_code;
  logic [7:0] letter;
  logic       hit;
  logic       miss;
  logic [7:0] score;
  logic [7:0] round;
  logic       busy;
  logic       done;

  practice_controller #(
    .TIMEOUT_TICKS  (16),
    .FEEDBACK_TICKS (4),
    .NUM_ROUNDS     (3)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .key_valid (key_valid),
    .key_code  (key_code),
    .letter    (letter),
    .hit       (hit),
    .miss      (miss),
    .score     (score),
    .round     (round),
    .busy      (busy),
    .done      (done)
  );

  always #5 clk = ~clk;

  // Independent model of the x^5+x^3+1 LFSR, stepped alongside the DUT.
  logic [4:0] lfsr_m;
  always @(posedge clk or posedge reset) begin
    if (reset) lfsr_m <= 5'b00001;
    else       lfsr_m <= {lfsr_m[3:0], lfsr_m[4] ^ lfsr_m[2]};
  end

  int n_chk  = 0;
  int n_fail = 0;
  logic [7:0] cur_letter;
  logic [7:0] first_letter;
  logic [7:0] wrong;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    assert (got === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic send_key(input logic [7:0] k);
    key_valid = 1'b1;
    key_code  = k;
    @(negedge clk);
    key_valid = 1'b0;
    key_code  = 8'h00;
  endtask

  // Called at the negedge after the edge that entered PICK. Ends at the
  // negedge after the WAIT-entry edge.
  task automatic pick(input string tag);
    logic [4:0] pv;
    bit found;
    found = 1'b0;
    pv = 5'd0;
    for (int i = 0; i < 6 && !found; i++) begin
      pv = lfsr_m;
      @(negedge clk);
      if (pv >= 5'd1 && pv <= 5'd26) found = 1'b1;
    end
    chk({tag, "_found"}, 32'(found), 32'd1);
    cur_letter = found ? (8'h40 + {3'b000, pv}) : 8'h00;
    chk({tag, "_letter"}, 32'(letter), 32'(cur_letter));
    chk({tag, "_busy"}, 32'(busy), 32'd1);
    chk({tag, "_lfsr"}, 32'(dut.u_lfsr.value), 32'(lfsr_m));
  endtask

  // Called at the negedge after the edge that entered FEEDBACK.
  task automatic feedback(input string tag, input logic eh, input logic em,
                          input logic [7:0] es, input logic [7:0] er, input bit last);
    chk({tag, "_hit"}, 32'(hit), 32'(eh));
    chk({tag, "_miss"}, 32'(miss), 32'(em));
    chk({tag, "_score"}, 32'(score), 32'(es));
    for (int i = 1; i < 4; i++) begin
      @(negedge clk);
      chk({tag, "_hold_hit"}, 32'(hit), 32'(eh));
      chk({tag, "_hold_miss"}, 32'(miss), 32'(em));
    end
    @(negedge clk);
    chk({tag, "_end_hit"}, 32'(hit), 32'd0);
    chk({tag, "_end_miss"}, 32'(miss), 32'd0);
    chk({tag, "_round"}, 32'(round), 32'(er));
    if (last) begin
      chk({tag, "_done"}, 32'(done), 32'd1);
      chk({tag, "_done_letter"}, 32'(letter), 32'h00);
      chk({tag, "_done_busy"}, 32'(busy), 32'd0);
      chk({tag, "_done_score"}, 32'(score), 32'(es));
    end else begin
      chk({tag, "_busy"}, 32'(busy), 32'd1);
    end
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_letter"}, 32'(letter), 32'h00);
    chk({tag, "_hit"}, 32'(hit), 32'd0);
    chk({tag, "_miss"}, 32'(miss), 32'd0);
    chk({tag, "_score"}, 32'(score), 32'd0);
    chk({tag, "_round"}, 32'(round), 32'd0);
    chk({tag, "_busy"}, 32'(busy), 32'd0);
    chk({tag, "_done"}, 32'(done), 32'd0);
    chk({tag, "_lfsr"}, 32'(dut.u_lfsr.value), 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset     = 1'b1;
    start     = 1'b0;
    key_valid = 1'b0;
    key_code  = 8'h00;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    chk_reset_outputs("rst");

    // Game 1, round 1: 0x31 ignored, exact uppercase hits.
    @(negedge clk);
    pulse_start();
    chk("start_busy", 32'(busy), 32'd1);
    chk("start_letter_blank", 32'(letter), 32'h00);
    pick("g1r1");
    first_letter = cur_letter;
    chk("g1r1_hand_letter", 32'(letter), 32'h44);
    send_key(8'h31);
    chk("ignore_hit", 32'(hit), 32'd0);
    chk("ignore_miss", 32'(miss), 32'd0);
    chk("ignore_letter", 32'(letter), 32'(cur_letter));
    send_key(cur_letter);
    feedback("g1r1_fb", 1'b1, 1'b0, 8'd1, 8'd1, 1'b0);

    // Round 2: start during WAIT ignored, wrong uppercase misses.
    pick("g1r2");
    pulse_start();
    chk("wait_start_letter", 32'(letter), 32'(cur_letter));
    chk("wait_start_score", 32'(score), 32'd1);
    chk("wait_start_round", 32'(round), 32'd1);
    chk("wait_start_busy", 32'(busy), 32'd1);
    wrong = (cur_letter == 8'h41) ? 8'h5A : 8'h41;
    send_key(wrong);
    feedback("g1r2_fb", 1'b0, 1'b1, 8'd1, 8'd2, 1'b0);

    // Round 3: lowercase hits, game ends.
    pick("g1r3");
    send_key(cur_letter + 8'h20);
    feedback("g1r3_fb", 1'b1, 1'b0, 8'd2, 8'd3, 1'b1);

    // DONE freezes score/round and ignores keys.
    @(negedge clk);
    send_key(8'h41);
    chk("done_hold_score", 32'(score), 32'd2);
    chk("done_hold_round", 32'(round), 32'd3);
    chk("done_hold_done", 32'(done), 32'd1);
    chk("done_hold_hit", 32'(hit), 32'd0);

    // Game 2: restart from DONE.
    pulse_start();
    chk("g2_done", 32'(done), 32'd0);
    chk("g2_score", 32'(score), 32'd0);
    chk("g2_round", 32'(round), 32'd0);
    chk("g2_busy", 32'(busy), 32'd1);
    pick("g2r1");
    repeat (15) @(negedge clk);
    chk("to_early_miss", 32'(miss), 32'd0);
    chk("to_early_hit", 32'(hit), 32'd0);
    @(negedge clk);
    feedback("g2r1_to", 1'b0, 1'b1, 8'd0, 8'd1, 1'b0);

    // Key in the expiry cycle wins.
    pick("g2r2");
    repeat (15) @(negedge clk);
    send_key(cur_letter);
    chk("expiry_hit", 32'(hit), 32'd1);
    chk("expiry_miss", 32'(miss), 32'd0);
    chk("expiry_score", 32'(score), 32'd1);

    // Asynchronous reset during FEEDBACK.
    @(negedge clk);
    reset = 1'b1;
    #1;
    chk_reset_outputs("async_rst");
    repeat (2) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    pulse_start();
    chk("post_rst_score", 32'(score), 32'd0);
    chk("post_rst_round", 32'(round), 32'd0);
    pick("post_rst");
    chk("post_rst_same_letter", 32'(letter), 32'(first_letter));

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
